// File: rtl/counter_pkg.sv
// Shared constants and types for the up/down counter family.
package counter_pkg;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    // What the counter does on a given edge, after priority resolution.
    typedef enum logic [1:0] {
        ActHold,
        ActLoad,
        ActInc,
        ActDec
    } act_e;

endpackage

// File: rtl/counter_updown_param_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
interface counter_updown_param_if #(
    parameter int unsigned WIDTH = 4
);

    logic             en;
    logic             isUP;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] q;
    logic             tc_max;
    logic             tc_zero;
    logic             evt;

    modport master (
        output en,
        output isUP,
        output load,
        output load_val,
        output max_val,
        input  q,
        input  tc_max,
        input  tc_zero,
        input  evt
    );

    modport slave (
        input  en,
        input  isUP,
        input  load,
        input  load_val,
        input  max_val,
        output q,
        output tc_max,
        output tc_zero,
        output evt
    );

endinterface

// File: rtl/counter_prescaler.sv
// Enable divider: tick is high on every PRESCALE-th enabled cycle.
module counter_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] Last = CntW'(PRESCALE - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == Last);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_updown_param.sv
// Parametrised up/down counter with load, terminal value and wrap/saturate modes.
// Optional enable prescaler built only when COUNTER_PRESCALE_EN is defined.
module counter_updown_param
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned PRESCALE = 4
) (
    input logic                   clk,
    input logic                   reset,
    counter_updown_param_if.slave bus
);

    if (WIDTH < 2) begin : g_bad_width
        $error("counter_updown_param: WIDTH must be >= 2");
    end
    if (SATURATE > MODE_SAT) begin : g_bad_mode
        $error("counter_updown_param: SATURATE must be 0 or 1");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("counter_updown_param: PRESCALE must be >= 1");
    end

    localparam bit Sat = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] q_q, q_d;
    logic             evt_q, evt_d;
    logic             step;
    act_e             act;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (bus.en),
        .clr  (bus.load),
        .tick (step)
    );
`else
    assign step = bus.en;
`endif

    always_comb begin
        act = ActHold;
        if (bus.load) begin
            act = ActLoad;
        end else if (step) begin
            act = bus.isUP ? ActInc : ActDec;
        end
    end

    always_comb begin
        q_d   = q_q;
        evt_d = 1'b0;
        unique case (act)
            ActHold: ;
            ActLoad: begin
                q_d = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
            end
            ActInc: begin
                // Also covers q above a freshly lowered max_val.
                if (q_q < bus.max_val) begin
                    q_d = q_q + WIDTH'(1);
                end else begin
                    q_d   = Sat ? bus.max_val : '0;
                    evt_d = 1'b1;
                end
            end
            ActDec: begin
                if (q_q == '0) begin
                    q_d   = Sat ? '0 : bus.max_val;
                    evt_d = 1'b1;
                end else if (q_q > bus.max_val) begin
                    q_d = bus.max_val;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= '0;
            evt_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            evt_q <= evt_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.evt     = evt_q;
    assign bus.tc_max  = (q_q == bus.max_val);
    assign bus.tc_zero = (q_q == '0);

endmodule

// File: tb/tb_counter_updown_param.sv
// Bench for counter_updown_param: wrap and saturate instances share stimulus and are
// checked every cycle against a behavioural model, plus literal scenario checks.
module tb_counter_updown_param;

    localparam int unsigned W = 4;
`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned PS = 4;
`else
    localparam int unsigned PS = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         en, up, ld;
    logic [W-1:0] ld_val, mx;

    counter_updown_param_if #(.WIDTH(W)) bus_w ();
    counter_updown_param_if #(.WIDTH(W)) bus_s ();

    assign bus_w.en = en;       assign bus_s.en = en;
    assign bus_w.isUP = up;     assign bus_s.isUP = up;
    assign bus_w.load = ld;     assign bus_s.load = ld;
    assign bus_w.load_val = ld_val; assign bus_s.load_val = ld_val;
    assign bus_w.max_val = mx;  assign bus_s.max_val = mx;

    counter_updown_param #(.WIDTH(W), .SATURATE(0), .PRESCALE(PS)) dut_w (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_w.slave)
    );

    counter_updown_param #(.WIDTH(W), .SATURATE(1), .PRESCALE(PS)) dut_s (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_s.slave)
    );

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: index 0 = wrap instance, 1 = saturate instance.
    int mq[2];
    bit mevt[2];
    int mpre[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit sat;
            bit stp;
            sat = (i == 1);
            stp = 1'b0;
            if (reset) begin
                mq[i] = 0; mevt[i] = 0; mpre[i] = 0;
            end else if (ld) begin
                mq[i] = (ld_val > mx) ? int'(mx) : int'(ld_val);
                mevt[i] = 0; mpre[i] = 0;
            end else begin
                mevt[i] = 0;
                if (en) begin
                    if (mpre[i] == PS - 1) begin stp = 1'b1; mpre[i] = 0; end
                    else mpre[i]++;
                end
                if (stp) begin
                    if (up) begin
                        if (mq[i] < int'(mx)) mq[i]++;
                        else begin mq[i] = sat ? int'(mx) : 0; mevt[i] = 1; end
                    end else if (mq[i] == 0) begin
                        mq[i] = sat ? 0 : int'(mx); mevt[i] = 1;
                    end else if (mq[i] > int'(mx)) begin
                        mq[i] = int'(mx);
                    end else begin
                        mq[i]--;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("cmp_q_wrap", 32'(bus_w.q), mq[0]);
            check("cmp_evt_wrap", 32'(bus_w.evt), 32'(mevt[0]));
            check("cmp_tcmax_wrap", 32'(bus_w.tc_max), 32'(mq[0] == int'(mx)));
            check("cmp_tczero_wrap", 32'(bus_w.tc_zero), 32'(mq[0] == 0));
            check("cmp_q_sat", 32'(bus_s.q), mq[1]);
            check("cmp_evt_sat", 32'(bus_s.evt), 32'(mevt[1]));
            check("cmp_tcmax_sat", 32'(bus_s.tc_max), 32'(mq[1] == int'(mx)));
            check("cmp_tczero_sat", 32'(bus_s.tc_zero), 32'(mq[1] == 0));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One effective count step (PS enabled cycles when prescaled).
    task automatic step(input bit dir);
        en = 1'b1; up = dir;
        repeat (PS) cyc();
        en = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        ld = 1'b1; ld_val = v;
        cyc();
        ld = 1'b0;
    endtask

    initial begin
        int exp_q;
        reset = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; ld_val = '0; mx = 4'd9;
        cyc();
        reset = 1'b0;
        chk_on = 1'b1;
        check("reset_q", 32'(bus_w.q), 0);
        check("reset_evt", 32'(bus_w.evt), 0);
        check("reset_tczero", 32'(bus_w.tc_zero), 1);

        // Count up through the terminal value.
        for (int k = 1; k <= 11; k++) begin
            step(1'b1);
            exp_q = k % 10;
            check("up_q", 32'(bus_w.q), exp_q);
            check("up_model_q", mq[0], exp_q);
            check("up_evt", 32'(bus_w.evt), 32'(k == 10));
            check("up_tcmax", 32'(bus_w.tc_max), 32'(exp_q == 9));
        end

        // Down through zero.
        do_load(4'd1);
        check("dn_load_q", 32'(bus_w.q), 1);
        step(1'b0);
        check("dn_q0", 32'(bus_w.q), 0);
        check("dn_tczero", 32'(bus_w.tc_zero), 1);
        check("dn_evt0", 32'(bus_w.evt), 0);
        step(1'b0);
        check("dn_q9", 32'(bus_w.q), 9);
        check("dn_evt9", 32'(bus_w.evt), 1);
        step(1'b0);
        check("dn_q8", 32'(bus_w.q), 8);
        check("dn_evt8", 32'(bus_w.evt), 0);

        // Saturate instance.
        mx = 4'd5;
        do_load(4'd4);
        step(1'b1);
        check("sat_q1", 32'(bus_s.q), 5);
        check("sat_evt1", 32'(bus_s.evt), 0);
        step(1'b1);
        check("sat_q2", 32'(bus_s.q), 5);
        check("sat_evt2", 32'(bus_s.evt), 1);
        step(1'b1);
        check("sat_q3", 32'(bus_s.q), 5);
        check("sat_evt3", 32'(bus_s.evt), 1);
        do_load(4'd0);
        step(1'b0);
        check("sat_dn_q", 32'(bus_s.q), 0);
        check("sat_dn_evt", 32'(bus_s.evt), 1);
        check("sat_dn_model", mq[1], 0);

        // Priority: reset > load > en.
        mx = 4'd9;
        reset = 1'b1; ld = 1'b1; ld_val = 4'd7; en = 1'b1; up = 1'b1;
        cyc();
        check("prio_reset_q", 32'(bus_w.q), 0);
        reset = 1'b0;
        cyc();
        check("prio_load_q", 32'(bus_w.q), 7);
        ld_val = 4'd12;
        cyc();
        check("prio_clamp_q", 32'(bus_w.q), 9);
        check("prio_clamp_sat", 32'(bus_s.q), 9);
        ld = 1'b0; en = 1'b0;

        // Runtime lowering of max_val.
        do_load(4'd8);
        mx = 4'd3;
        step(1'b1);
        check("low_up_q", 32'(bus_w.q), 0);
        check("low_up_evt", 32'(bus_w.evt), 1);
        check("low_up_sat_q", 32'(bus_s.q), 3);
        mx = 4'd9;
        do_load(4'd8);
        mx = 4'd3;
        step(1'b0);
        check("low_dn_q", 32'(bus_w.q), 3);
        check("low_dn_evt", 32'(bus_w.evt), 0);

        // max_val == 0 pins the counter and pulses evt every step.
        mx = 4'd0;
        do_load(4'd0);
        step(1'b1);
        check("mx0_q", 32'(bus_w.q), 0);
        check("mx0_evt_w", 32'(bus_w.evt), 1);
        check("mx0_evt_s", 32'(bus_s.evt), 1);
        check("mx0_tcmax", 32'(bus_w.tc_max), 1);

`ifdef COUNTER_PRESCALE_EN
        mx = 4'd9;
        reset = 1'b1; cyc(); reset = 1'b0;
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check("ps_q", 32'(bus_w.q), k / 4);
        end
        repeat (2) cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        check("ps_reset_q", 32'(bus_w.q), 0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("ps_restart_q", 32'(bus_w.q), k / 4);
        end
        en = 1'b0;
`endif

        // Randomized phase; the compare process does the checking.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            ld = ($urandom_range(0, 15) == 0);
            en = ($urandom_range(0, 3) != 0);
            up = 1'($urandom_range(0, 1));
            ld_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) begin
                mx = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 2))
                                                 : 4'($urandom_range(0, 15));
            end
            cyc();
        end
        reset = 1'b0; ld = 1'b0; en = 1'b0;
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_updown_param.md
Name: counter_updown_param

Overview:
Parametrised up/down counter, the next generation of the team's 4-bit up/down counter. It adds configurable width, a runtime terminal value, and synchronous load and enable. It supports wrap or saturate mode, terminal-count flags and a registered wrap/saturate event pulse. It is used as a general event/timebase counter (e.g. BCD digit chains, timers) in the single-clock domain.

Parameters:
WIDTH, 4, counter width in bits (>=2)
SATURATE, 0, 0 = modulo (wrap) mode, 1 = saturate mode
PRESCALE, 4, enable divide ratio (>=1); used only when COUNTER_PRESCALE_EN is defined

Ports:
clk  input  1  rising-edge clock; sole clock
reset  input  1  synchronous, active-high reset
en  input  1  count enable; one step per enabled cycle
isUP  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous load strobe
load_val  input  WIDTH  value to load
max_val  input  WIDTH  terminal (top) value; count range is 0..max_val
q  output  WIDTH  current count (registered)
tc_max  output  1  combinational: q == max_val
tc_zero  output  1  combinational: q == 0
evt  output  1  registered one-cycle pulse on wrap (SATURATE=0) or on blocked step at a limit (SATURATE=1)

Behaviour:
- Reset is synchronous, active-high, sampled on rising clk only. On reset: q=0, evt=0, prescaler=0. Reset mid-count is applied at the next edge, with no async path.
- Priority per edge: reset > load > en. When none is active, q holds and evt=0.
- Load: q <= min(load_val, max_val); evt=0. The direction and en inputs are ignored that cycle.
- Step (en=1, no load), latency 1 cycle (q reflects the step on the edge where en is sampled):
  - up, q < max_val: q <= q+1.
  - up, q >= max_val: wrap mode gives q <= 0, evt <= 1; saturate mode gives q <= max_val, evt <= 1.
  - down, 0 < q <= max_val: q <= q-1.
  - down, q == 0: wrap mode gives q <= max_val, evt <= 1; saturate mode gives q <= 0 (hold), evt <= 1.
  - down, q > max_val (max_val lowered at runtime): q <= max_val, evt=0.
- max_val == 0: the counter stays at 0. In wrap mode evt pulses every step; in saturate mode evt pulses every step.
- Arithmetic is WIDTH-bit unsigned. No carry is ever exposed except through evt. max_val = 2^WIDTH-1 reproduces natural binary roll-over.
- evt is high exactly one cycle per qualifying step and is 0 in all other cycles.
- tc_max and tc_zero are pure decodes of the q register and max_val, with no extra latency. When max_val == 0, both are 1.
- Direction may change on any cycle. The new direction applies to that cycle's step.

Optional Feature:
Macro COUNTER_PRESCALE_EN.
- Defined: en feeds an internal prescaler counting 0..PRESCALE-1. A step occurs only in the enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0. The prescaler is cleared by reset and by load. When en=0, the prescaler holds.
- Not defined: every en=1 cycle steps, PRESCALE is ignored, and no prescaler logic exists.

Decomposition:
- Shared package counter_pkg: constants MODE_WRAP=0 and MODE_SAT=1.
- One natural sub-module: counter_prescaler (PRESCALE parameter, clk/reset/en/clr in, tick out). It is instantiated only under COUNTER_PRESCALE_EN.

Test Plan:
- Reset then count up: WIDTH=4, max_val=9, wrap mode, en=1, isUP=1 for 11 cycles. Required: q = 1..9, 0, 1; evt=1 only in the cycle after q=9; tc_max=1 while q=9.
- Down through zero: wrap mode, max_val=9, load_val=1 load, then en=1, isUP=0 for 3 cycles. Required: q = 1, 0, 9, 8; evt pulses once (with q=9); tc_zero=1 while q=0.
- Saturate: SATURATE=1, max_val=5, load 4, up 3 steps. Required: q = 5, 5, 5 with evt=1 on the 2nd and 3rd steps. Then down from 0 while holding: q stays 0 and evt pulses.
- Priority: assert reset, load (load_val=7) and en together. Required: q=0. Then load+en: q=7, no step. Then load_val=12 with max_val=9: q=9.
- Runtime max_val lowering: q=8, set max_val=3. An up step gives q=0 (wrap) with evt=1; a down step from 8 gives q=3 with evt=0.
- Prescale (COUNTER_PRESCALE_EN, PRESCALE=4): en=1 for 8 cycles gives q steps exactly twice (cycles 4 and 8). Reset asserted mid-sequence gives q=0, and the prescaler restarts so the next step is 4 enabled cycles later.
